// File: rtl/des_expand_keymix_if.sv
// Handshake bundle for des_expand_keymix: word in (R, K, mix_en),
// S-box group beats out.
interface des_expand_keymix_if #(
    parameter int GROUPS_PER_BEAT = 2
);
    localparam int W = 6 * GROUPS_PER_BEAT;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   r_in;
    logic [47:0]   subkey;
    logic          mix_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    out_group_idx;
    logic          out_last;

    modport master (
        output in_valid, r_in, subkey, mix_en, out_ready,
        input  in_ready, out_valid, out_data, out_group_idx, out_last
    );

    modport slave (
        input  in_valid, r_in, subkey, mix_en, out_ready,
        output in_ready, out_valid, out_data, out_group_idx, out_last
    );
endinterface

// File: rtl/des_expand_keymix.sv
// DES E-expansion with optional subkey XOR, streamed out as 6-bit
// S-box groups, GROUPS_PER_BEAT groups per beat.
module des_expand_keymix #(
    parameter int GROUPS_PER_BEAT = 2
) (
    input logic                clk,
    input logic                rst,
    des_expand_keymix_if.slave bus
);
    localparam int BEATS = 8 / GROUPS_PER_BEAT;
    localparam int W     = 6 * GROUPS_PER_BEAT;

    generate
        if (GROUPS_PER_BEAT != 1 && GROUPS_PER_BEAT != 2 &&
            GROUPS_PER_BEAT != 4 && GROUPS_PER_BEAT != 8) begin : g_bad_g
            $error("GROUPS_PER_BEAT must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_beat;
    logic [47:0] r_shreg;
    logic [47:0] w_exp;
    logic [47:0] w_word;
    logic [2:0]  w_idx;
    logic        w_send;
    logic        w_last;
    logic        w_ready;
    logic        w_cap;
    logic        w_shift;

    // Each group takes its own nibble plus the neighbouring bit on either side.
    always_comb begin
        w_exp = '0;
        for (int g = 0; g < 8; g++) begin
            w_exp[6'(47 - 6 * g) -: 6] = {
                bus.r_in[5'(4 * g + 31)],
                bus.r_in[5'(4 * g)],
                bus.r_in[5'(4 * g + 1)],
                bus.r_in[5'(4 * g + 2)],
                bus.r_in[5'(4 * g + 3)],
                bus.r_in[5'(4 * g + 4)]
            };
        end
    end

    assign w_word = w_exp ^ (bus.mix_en ? bus.subkey : 48'h0);
    assign w_send = (r_state == S_SEND) && !rst;
    assign w_last = w_send && (r_beat == 3'(BEATS - 1));
    assign w_idx  = 3'(GROUPS_PER_BEAT * int'(r_beat));

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_cap   = 1'b0;
        w_shift = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_cap  = 1'b1;
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    if (!w_last) begin
                        w_shift = 1'b1;
                    end else begin
                        w_ready = 1'b1;
                        if (bus.in_valid) w_cap = 1'b1;
                        else              w_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= 3'd0;
            r_shreg <= 48'h0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_shreg <= w_word;
                r_beat  <= 3'd0;
            end else if (w_shift) begin
                r_shreg <= r_shreg << W;
                r_beat  <= r_beat + 3'd1;
            end
        end
    end

    assign bus.in_ready      = w_ready && !rst;
    assign bus.out_valid     = w_send;
    assign bus.out_data      = w_send ? r_shreg[47 -: W] : '0;
    assign bus.out_group_idx = w_send ? w_idx : 3'd0;
    assign bus.out_last      = w_last;
endmodule

// File: tb/tb_des_expand_keymix.sv
// Bench for des_expand_keymix: one DUT per legal group count,
// checked against a DES E-table reference model.
module tb_des_expand_keymix;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] r_in;
    logic [47:0] subkey;
    logic        mix_en;
    logic        iv[4];
    logic        ordy[4];
    logic        ir[4];
    logic        ov[4];
    logic        ol[4];
    logic [2:0]  gi[4];
    logic [47:0] od[4];

    int n_cmp = 0;
    int n_bad = 0;
    int etab[48];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        des_expand_keymix_if #(.GROUPS_PER_BEAT(1 << k)) bus ();
        des_expand_keymix #(.GROUPS_PER_BEAT(1 << k)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign bus.in_valid  = iv[k];
        assign bus.r_in      = r_in;
        assign bus.subkey    = subkey;
        assign bus.mix_en    = mix_en;
        assign bus.out_ready = ordy[k];
        assign ir[k] = bus.in_ready;
        assign ov[k] = bus.out_valid;
        assign ol[k] = bus.out_last;
        assign gi[k] = bus.out_group_idx;
        assign od[k] = 48'(bus.out_data) << (48 - 6 * (1 << k));
    end

    // Standard DES E selection table, 1-based R bit numbers.
    function automatic logic [47:0] ref_word(logic [31:0] r, logic [47:0] key, logic m);
        logic [47:0] e;
        for (int j = 0; j < 48; j++) e[47 - j] = r[etab[j] - 1];
        return m ? (e ^ key) : e;
    endfunction

    function automatic logic [47:0] ref_beat(logic [47:0] w, int g, int b);
        logic [47:0] mask;
        mask = ~48'h0 << (48 - 6 * g);
        return (w << (6 * g * b)) & mask;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1; iv[1] = 1'b1; ordy[1] = 1'b1;
            r_in = $urandom; mix_en = 1'b1;
            #1;
            n_cmp++;
            if ({ir[1], ov[1], ol[1], gi[1], od[1]} !== 54'h0) begin
                n_bad++;
                $display("FAIL reset_outs: got ir=%b ov=%b ol=%b gi=%0d od=%h want all 0",
                         ir[1], ov[1], ol[1], gi[1], od[1]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b0; iv[1] = 1'b0;
            #1;
            n_cmp++;
            if ({ov[1], ol[1], gi[1], od[1]} !== 53'h0) begin
                n_bad++;
                $display("FAIL reset_nocapture: got ov=%b od=%h want 0", ov[1], od[1]);
            end
        end
    endtask

    task automatic test_wrap_bits();
        logic [11:0] eb[4];
        eb = '{12'h800, 12'h000, 12'h000, 12'h002};
        @(negedge clk);
        r_in = 32'h80000000; subkey = 48'hA5A5A5A5A5A5; mix_en = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b1;
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_ready: got %b want 1", ir[1]);
        end
        @(negedge clk);
        iv[1] = 1'b0; r_in = $urandom;
        #1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(negedge clk);
                #1;
            end
            n_cmp++;
            if ({ov[1], ol[1], gi[1], od[1][47 -: 12]} !== {1'b1, b == 3, 3'(2 * b), eb[b]}) begin
                n_bad++;
                $display("FAIL wrap_beat%0d: got v=%b l=%b i=%0d d=%h want v=1 l=%b i=%0d d=%h",
                         b, ov[1], ol[1], gi[1], od[1][47 -: 12], b == 3, 2 * b, eb[b]);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_idle: got ov=%b want 0", ov[1]);
        end
    endtask

    task automatic test_wrap_bit0();
        @(negedge clk);
        r_in = 32'h00000001; mix_en = 1'b0; subkey = 48'hFFFF00000000;
        iv[3] = 1'b1; ordy[3] = 1'b1;
        #1;
        @(negedge clk);
        iv[3] = 1'b0; r_in = $urandom;
        #1;
        n_cmp++;
        if ({ov[3], ol[3], gi[3], od[3]} !== {1'b1, 1'b1, 3'd0, 48'h400000000001}) begin
            n_bad++;
            $display("FAIL wrap0_beat: got v=%b l=%b i=%0d d=%h want v=1 l=1 i=0 d=400000000001",
                     ov[3], ol[3], gi[3], od[3]);
        end
        n_cmp++;
        if (ir[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap0_ready: got %b want 1", ir[3]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap0_idle: got ov=%b want 0", ov[3]);
        end
    endtask

    task automatic test_keymix();
        logic [23:0] eb[4];
        eb = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
        @(negedge clk);
        r_in = 32'h0; subkey = '1; mix_en = 1'b1;
        iv[2] = 1'b1; ordy[2] = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 1) begin
                r_in = 32'h0; subkey = '1; mix_en = 1'b0; iv[2] = 1'b1;
            end else begin
                r_in = $urandom; mix_en = 1'b1; iv[2] = 1'b0;
            end
            #1;
            n_cmp++;
            if ({ov[2], ol[2], gi[2], od[2][47 -: 24]} !==
                {1'b1, b[0], 3'(4 * b[0]), eb[b]}) begin
                n_bad++;
                $display("FAIL keymix_beat%0d: got v=%b l=%b i=%0d d=%h want d=%h",
                         b, ov[2], ol[2], gi[2], od[2][47 -: 24], eb[b]);
            end
            if (b == 1) begin
                n_cmp++;
                if (ir[2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL keymix_b2b_ready: got %b want 1", ir[2]);
                end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL keymix_idle: got ov=%b want 0", ov[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra[2];
        logic [47:0] ka[2];
        logic        ma[2];
        logic [47:0] ex[2];
        logic [47:0] eb;
        int b = 0;
        int stall = 0;
        for (int w = 0; w < 2; w++) begin
            ra[w] = $urandom;
            ka[w] = 48'({$urandom, $urandom});
            ma[w] = 1'($urandom);
            ex[w] = ref_word(ra[w], ka[w], ma[w]);
        end
        @(negedge clk);
        r_in = ra[0]; subkey = ka[0]; mix_en = ma[0];
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        while (b < 16) begin
            @(negedge clk);
            ordy[0] = !(b == 3 && stall < 5);
            if (b == 7) begin
                r_in = ra[1]; subkey = ka[1]; mix_en = ma[1]; iv[0] = 1'b1;
            end else begin
                r_in = $urandom; mix_en = 1'($urandom); iv[0] = 1'b0;
            end
            #1;
            eb = ref_beat(ex[b / 8], 1, b % 8);
            n_cmp++;
            if ({ov[0], ol[0], gi[0], od[0]} !== {1'b1, (b % 8) == 7, 3'(b % 8), eb}) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got v=%b l=%b i=%0d d=%h want l=%b i=%0d d=%h",
                         b, ov[0], ol[0], gi[0], od[0], (b % 8) == 7, b % 8, eb);
            end
            if (b == 7 || !ordy[0]) begin
                n_cmp++;
                if (ir[0] !== (b == 7)) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready%0d: got %b want %b", b, ir[0], b == 7);
                end
            end
            if (ordy[0]) b++;
            else         stall++;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        n_cmp++;
        if (ov[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got ov=%b want 0", ov[0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [47:0] ex;
        logic [47:0] eb;
        logic        leak;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            r_in = $urandom; subkey = 48'({$urandom, $urandom}); mix_en = 1'($urandom);
            ex = ref_word(r_in, subkey, mix_en);
            iv[0] = 1'b1; ordy[0] = 1'b1;
            #1;
            for (int b = 0; b < ((w == 0) ? 4 : 8); b++) begin
                @(negedge clk);
                iv[0] = 1'b0; r_in = $urandom;
                #1;
                eb = ref_beat(ex, 1, b);
                n_cmp++;
                if ({ov[0], ol[0], gi[0], od[0]} !== {1'b1, b == 7, 3'(b), eb}) begin
                    n_bad++;
                    $display("FAIL midrst_w%0d_beat%0d: got i=%0d d=%h want i=%0d d=%h",
                             w, b, gi[0], od[0], b, eb);
                end
            end
            if (w == 0) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                n_cmp++;
                if ({ir[0], ov[0], od[0]} !== 50'h0) begin
                    n_bad++;
                    $display("FAIL midrst_during: got ir=%b ov=%b od=%h want 0",
                             ir[0], ov[0], od[0]);
                end
                leak = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    leak = leak | ov[0];
                end
                n_cmp++;
                if (leak !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midrst_leak: got out_valid seen=%b want 0", leak);
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_random_stream();
        for (int k = 0; k < 4; k++) begin
            logic [47:0] q[$];
            logic [47:0] eb;
            int g = 1 << k;
            int sent = 0;
            int bidx = 0;
            int cyc = 0;
            while ((sent < 12 || q.size() > 0) && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                iv[k] = (sent < 12) && ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                r_in = $urandom;
                subkey = 48'({$urandom, $urandom});
                mix_en = 1'($urandom);
                #1;
                n_cmp++;
                if (ov[k] !== (q.size() != 0)) begin
                    n_bad++;
                    $display("FAIL rand_g%0d_valid: got %b want %b", g, ov[k], q.size() != 0);
                end
                if (ov[k] && ordy[k] && q.size() != 0) begin
                    eb = ref_beat(q[0], g, bidx);
                    n_cmp++;
                    if ({ol[k], gi[k], od[k]} !== {bidx == 8 / g - 1, 3'(bidx * g), eb}) begin
                        n_bad++;
                        $display("FAIL rand_g%0d_beat: got l=%b i=%0d d=%h want l=%b i=%0d d=%h",
                                 g, ol[k], gi[k], od[k], bidx == 8 / g - 1, bidx * g, eb);
                    end
                    bidx++;
                    if (bidx == 8 / g) begin
                        bidx = 0;
                        void'(q.pop_front());
                    end
                end
                if (iv[k] && ir[k]) begin
                    q.push_back(ref_word(r_in, subkey, mix_en));
                    sent++;
                end
            end
            n_cmp++;
            if (cyc >= 3000) begin
                n_bad++;
                $display("FAIL rand_g%0d_timeout: got %0d cycles want < 3000", g, cyc);
            end
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
    endtask

    initial begin
        etab = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                 12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
        rst = 1'b1;
        r_in = 32'h0;
        subkey = 48'h0;
        mix_en = 1'b0;
        iv = '{default: 1'b0};
        ordy = '{default: 1'b0};
        test_reset();
        test_wrap_bits();
        test_wrap_bit0();
        test_keymix();
        test_back_to_back();
        test_mid_reset();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
